// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared widths, reset default and FSM encoding for the
//                instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buf
//  Description : Synchronous FIFO holding returned {pc, instr} entries until
//                decode consumes them. Flush empties it in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             w_pop;
    logic             w_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == c_DEPTH);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    // A push into a full buffer is legal only when the head leaves the same cycle.
    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && !flush_i && (!full_o || w_pop);

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + AW'(1);
            if (w_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage; contents are only meaningful where count says so.
    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Owns the PC, issues in-order instruction memory requests,
//                buffers responses for decode and squashes wrong-path fetches
//                on a redirect from execute.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               instr_ready_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i
);

    localparam int                AW          = $clog2(BUF_DEPTH);
    localparam int                CW          = AW + 1;
    localparam logic [CW:0]       c_DEPTH_EXT = (CW+1)'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] c_PC_STEP   = ADDR_W'(4);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CW-1:0]      out_q;
    logic [ADDR_W-1:0]  ifq_q [BUF_DEPTH];
    logic [AW-1:0]      ifq_wptr_q;
    logic [AW-1:0]      ifq_rptr_q;

    logic               w_req;
    logic               w_issue;
    logic               w_rsp;
    logic               w_pop;
    logic               w_push;
    logic               w_flush;
    logic [CW-1:0]      w_out_next;
    logic [CW:0]        w_credit;
    logic [ADDR_W-1:0]  w_target;
    logic               w_buf_full;
    logic               w_buf_empty;
    logic [CW-1:0]      w_buf_count;
    logic [ENTRY_W-1:0] w_buf_head;

    assign w_target = word_align(redirect_pc_i);
    assign w_pop    = !w_buf_empty && instr_ready_i;

    // Every slot is either holding a word or reserved by an outstanding request;
    // a slot vacated by this cycle's pop can be reserved immediately, which keeps
    // the stream at one instruction per cycle with single-cycle memory.
    assign w_credit = {1'b0, out_q} + {1'b0, w_buf_count} - {{CW{1'b0}}, w_pop};
    assign w_req    = (state_q == RUN) && (w_credit < c_DEPTH_EXT) && !(w_buf_full && !w_pop);
    assign w_issue  = w_req && imem_gnt_i;

    // Responses with nothing outstanding belong to requests issued before reset.
    assign w_rsp      = imem_rvalid_i && (out_q != '0);
    assign w_out_next = out_q + CW'(w_issue) - CW'(w_rsp);

    // Next-state, PC and buffer control for the BOOT/RUN/DRAIN sequencing.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        w_push  = 1'b0;
        w_flush = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (redirect_i) pc_d = w_target;
            end
            RUN: begin
                if (w_issue) pc_d = pc_q + c_PC_STEP;
                if (redirect_i) begin
                    pc_d    = w_target;
                    w_flush = 1'b1;
                    if (w_out_next != '0) state_d = DRAIN;
                end else if (w_rsp) begin
                    w_push = 1'b1;
                end
            end
            DRAIN: begin
                if (redirect_i) pc_d = w_target;
                if (w_out_next == '0) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // FSM state, PC and outstanding-request counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= w_out_next;
        end
    end

    // In-flight PC queue pointers; kept in step with out_q in every state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifq_wptr_q <= '0;
            ifq_rptr_q <= '0;
        end else begin
            if (w_issue) ifq_wptr_q <= ifq_wptr_q + AW'(1);
            if (w_rsp)   ifq_rptr_q <= ifq_rptr_q + AW'(1);
        end
    end

    // In-flight PC storage: the address of each granted request, oldest first.
    always_ff @(posedge clk_i) begin
        if (w_issue) ifq_q[ifq_wptr_q] <= pc_q;
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fetch_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  ({ifq_q[ifq_rptr_q], imem_rdata_i}),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .data_o  (w_buf_head),
        .full_o  (w_buf_full),
        .empty_o (w_buf_empty),
        .count_o (w_buf_count)
    );

    assign imem_req_o    = w_req;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = !w_buf_empty;
    assign instr_o       = instr_valid_o ? w_buf_head[INSTR_W-1:0]       : '0;
    assign instr_pc_o    = instr_valid_o ? w_buf_head[ENTRY_W-1:INSTR_W] : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit with a responsive
//                memory model and an in-order {pc, instr} scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'hFFFF_FFF8;
    localparam int          c_DEPTH    = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i    = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i  = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        redirect_i    = 1'b0;
    logic [31:0] redirect_pc_i = '0;

    instr_fetch_unit #(
        .RESET_PC  (c_RESET_PC),
        .BUF_DEPTH (c_DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Model and scoreboard state
    logic [63:0] exp_q [$];
    logic [31:0] mem_q [$];
    logic [31:0] exp_pc     = c_RESET_PC;
    logic [31:0] redir_tgt  = '0;
    logic [31:0] first_pcs [3];
    int          squash     = 0;
    int          sq0        = 0;
    int          grants     = 0;
    int          delivered  = 0;
    int          since_rst  = 0;
    bit          prev_hold  = 0;
    bit          want_first = 0;
    bit          first_grant = 1;
    bit          chk_stream = 0;
    bit          chk_coinc  = 0;
    bit          stale_inj  = 0;
    int          gnt_pct = 100, rsp_pct = 100, rdy_pct = 100;

    // Memory and decode-side driver, updated away from the sampling edge.
    always @(negedge clk_i) begin
        imem_gnt_i    = (int'($urandom_range(99)) < gnt_pct);
        instr_ready_i = (int'($urandom_range(99)) < rdy_pct);
        if (stale_inj) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end else if (mem_q.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
    end

    // Monitor: pre-edge values of all handshakes are sampled here.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            check_eq("stale_valid", instr_valid_o && (exp_q.size() == 0), 1'b0);
            if (prev_hold) check_eq("hold_valid", instr_valid_o, 1'b1);
            if (chk_stream) check_eq("stream_valid", instr_valid_o, 1'b1);
            if (redirect_i && chk_coinc)
                check_eq("coincide", {instr_valid_o && instr_ready_i, imem_rvalid_i}, 2'b11);
            if (instr_valid_o && exp_q.size() > 0) begin
                check_eq("instr_pc", instr_pc_o, exp_q[0][63:32]);
                check_eq("instr", instr_o, exp_q[0][31:0]);
                if (instr_ready_i) begin
                    if (want_first) begin
                        check_eq("redir_first_pc", instr_pc_o, redir_tgt);
                        want_first = 0;
                    end
                    if (since_rst < 3) first_pcs[since_rst] = instr_pc_o;
                    since_rst++;
                    delivered++;
                    void'(exp_q.pop_front());
                end
            end
            prev_hold = instr_valid_o && !instr_ready_i && !redirect_i;

            sq0 = squash;
            if (imem_rvalid_i && mem_q.size() > 0) begin
                void'(mem_q.pop_front());
                if (squash > 0) squash--;
            end
            if (imem_req_o) check_eq("req_in_drain", sq0 != 0, 1'b0);
            if (imem_req_o && imem_gnt_i) begin
                check_eq("req_addr", imem_addr_o, exp_pc);
                if (first_grant) begin
                    check_eq("first_addr", imem_addr_o, c_RESET_PC);
                    first_grant = 0;
                end
                mem_q.push_back(imem_addr_o);
                grants++;
            end
            if (redirect_i) begin
                exp_q.delete();
                exp_pc     = redirect_pc_i & 32'hFFFF_FFFC;
                redir_tgt  = exp_pc;
                want_first = 1;
                squash     = mem_q.size();
            end else if (imem_req_o && imem_gnt_i) begin
                exp_q.push_back({exp_pc, mem_word(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        mem_q.delete();
        exp_pc      = c_RESET_PC;
        squash      = 0;
        grants      = 0;
        since_rst   = 0;
        prev_hold   = 0;
        want_first  = 0;
        first_grant = 1;
    endtask

    // Asserts reset between edges and checks outputs respond immediately.
    task automatic do_reset();
        tick();
        rst_i = 1'b1;
        #1;
        check_eq("rst_req", imem_req_o, 1'b0);
        check_eq("rst_addr", imem_addr_o, c_RESET_PC);
        check_eq("rst_valid", instr_valid_o, 1'b0);
        check_eq("rst_instr", instr_o, 32'h0);
        check_eq("rst_pc", instr_pc_o, 32'h0);
        clear_model();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic wait_deliv(input int n, input int budget);
        int target;
        target = delivered + n;
        for (int i = 0; i < budget; i++) begin
            if (delivered >= target) break;
            tick();
        end
        check_eq("deliv_done", delivered >= target, 1'b1);
    endtask

    initial begin
        // Reset, streaming from a PC that wraps through zero
        gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
        do_reset();
        wait_deliv(2, 20);
        chk_stream = 1;
        repeat (8) tick();
        chk_stream = 0;
        check_eq("wrap_pc0", first_pcs[0], 32'hFFFF_FFF8);
        check_eq("wrap_pc1", first_pcs[1], 32'hFFFF_FFFC);
        check_eq("wrap_pc2", first_pcs[2], 32'h0000_0000);

        // Decode stalled: requests stop once the buffer is fully committed
        rdy_pct = 0;
        do_reset();
        repeat (10) tick();
        check_eq("stall_grants", grants, c_DEPTH);
        check_eq("stall_req", imem_req_o, 1'b0);
        check_eq("stall_valid", instr_valid_o, 1'b1);
        rdy_pct = 100;
        wait_deliv(4, 20);

        // Redirect with two requests outstanding
        rdy_pct = 0; rsp_pct = 0;
        do_reset();
        repeat (4) tick();
        check_eq("outstanding", mem_q.size(), 2);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        rsp_pct = 100; rdy_pct = 100;
        tick();
        redirect_i = 1'b0;
        wait_deliv(3, 30);

        // Redirect landing on a cycle with both a pop and a response
        wait_deliv(4, 20);
        chk_coinc = 1;
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_2000;
        tick();
        redirect_i = 1'b0; chk_coinc = 0;
        wait_deliv(4, 20);

        // Random stalls on every interface with sporadic redirects
        gnt_pct = 70; rsp_pct = 60; rdy_pct = 70;
        for (int i = 0; i < 400; i++) begin
            if (!redirect_i && $urandom_range(99) < 4) begin
                redirect_i    = 1'b1;
                redirect_pc_i = $urandom;
            end else begin
                redirect_i = 1'b0;
            end
            tick();
        end
        redirect_i = 1'b0;
        gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
        wait_deliv(4, 50);

        // Reset mid-stream with two outstanding; a stale response follows
        rdy_pct = 0; rsp_pct = 0;
        do_reset();
        repeat (4) tick();
        check_eq("pre_rst_outstanding", mem_q.size(), 2);
        tick();
        rst_i = 1'b1;
        #1;
        check_eq("mid_rst_req", imem_req_o, 1'b0);
        check_eq("mid_rst_addr", imem_addr_o, c_RESET_PC);
        check_eq("mid_rst_valid", instr_valid_o, 1'b0);
        check_eq("mid_rst_instr", instr_o, 32'h0);
        check_eq("mid_rst_pc", instr_pc_o, 32'h0);
        clear_model();
        tick();
        rst_i = 1'b0; stale_inj = 1'b1; rdy_pct = 100; rsp_pct = 100;
        tick();
        stale_inj = 1'b0;
        wait_deliv(3, 20);
        check_eq("post_rst_pc0", first_pcs[0], c_RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
